// File: rtl/rat_path_player.sv
// rat_path_player: turns the maze controller's replayed move codes into absolute (x, y)
// coordinates, buffered in a small valid/ready output FIFO. Optional macro:
// RAT_PLAYER_BOUNDS_CHK_EN rejects off-maze moves (block enters ERR); without it coordinates wrap.
module rat_path_player #(
  parameter int X_W        = 4,
  parameter int Y_W        = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int STEP_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mv_valid,
  input  logic [1:0]        mv_dir,
  input  logic              mv_last,
  output logic              mv_ready,
  output logic              out_valid,
  output logic [X_W-1:0]    out_x,
  output logic [Y_W-1:0]    out_y,
  input  logic              out_ready,
  output logic [STEP_W-1:0] step_cnt,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int             PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ORIGIN = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [X_W-1:0]    pos_x_q, pos_x_d, nxt_x_s;
  logic [Y_W-1:0]    pos_y_q, pos_y_d, nxt_y_s;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [X_W-1:0]    mem_x_q [FIFO_DEPTH];
  logic [Y_W-1:0]    mem_y_q [FIFO_DEPTH];
  logic              fifo_full_s, run_s, push_s, pop_s, hs_s, bad_s, clear_s;

  assign fifo_full_s = (count_q == FULL_CNT);
  assign run_s       = (state_q == S_RUN);
  assign out_valid   = (count_q != {(PTR_W+1){1'b0}});
  assign pop_s       = out_valid & out_ready;

`ifdef RAT_PLAYER_BOUNDS_CHK_EN
  logic oob_s;

  // Flag a move whose target would leave the maze; it is never handshaked.
  always_comb begin
    case (mv_dir)
      2'b00:   oob_s = (pos_x_q == {X_W{1'b0}});
      2'b11:   oob_s = (pos_x_q == {X_W{1'b1}});
      2'b01:   oob_s = (pos_y_q == {Y_W{1'b1}});
      2'b10:   oob_s = (pos_y_q == {Y_W{1'b0}});
      default: oob_s = 1'b0;
    endcase
  end

  assign bad_s    = run_s & mv_valid & ~fifo_full_s & oob_s;
  assign mv_ready = run_s & ~fifo_full_s & ~(mv_valid & oob_s);
`else
  assign bad_s    = 1'b0;
  assign mv_ready = run_s & ~fifo_full_s;
`endif

  assign hs_s = mv_valid & mv_ready;

  // Target position of the offered move (wraps modulo the coordinate width).
  always_comb begin
    nxt_x_s = pos_x_q;
    nxt_y_s = pos_y_q;
    case (mv_dir)
      2'b00:   nxt_x_s = pos_x_q - X_W'(1);
      2'b11:   nxt_x_s = pos_x_q + X_W'(1);
      2'b01:   nxt_y_s = pos_y_q + Y_W'(1);
      2'b10:   nxt_y_s = pos_y_q - Y_W'(1);
      default: begin
        nxt_x_s = pos_x_q;
        nxt_y_s = pos_y_q;
      end
    endcase
  end

  // Sequencing, position tracking and status next-state.
  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    step_d  = step_q;
    push_s  = 1'b0;
    clear_s = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          clear_s = 1'b1;
          pos_x_d = {X_W{1'b0}};
          pos_y_d = {Y_W{1'b0}};
          step_d  = {STEP_W{1'b0}};
          state_d = S_ORIGIN;
        end else begin
          state_d = state_q;
        end
      end
      S_ORIGIN: begin
        push_s  = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (bad_s) begin
          clear_s = 1'b1;
          state_d = S_ERR;
        end else if (hs_s) begin
          pos_x_d = nxt_x_s;
          pos_y_d = nxt_y_s;
          push_s  = 1'b1;
          step_d  = (step_q == {STEP_W{1'b1}}) ? step_q : step_q + STEP_W'(1);
          state_d = mv_last ? S_DRAIN : S_RUN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: state_d = out_valid ? S_DRAIN : S_DONE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_ORIGIN) | (state_d == S_RUN) | (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
  end

  // FIFO pointer and occupancy bookkeeping; a clear discards everything buffered.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_s) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {(PTR_W+1){1'b0}};
    end else begin
      wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pos_x_q  <= {X_W{1'b0}};
      pos_y_q  <= {Y_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {(PTR_W+1){1'b0}};
      step_q   <= {STEP_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      step_q   <= step_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Coordinate storage; the pushed value is always the position being registered.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_x_q[wr_ptr_q] <= pos_x_d;
      mem_y_q[wr_ptr_q] <= pos_y_d;
    end
  end

  assign out_x    = out_valid ? mem_x_q[rd_ptr_q] : {X_W{1'b0}};
  assign out_y    = out_valid ? mem_y_q[rd_ptr_q] : {Y_W{1'b0}};
  assign step_cnt = step_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_rat_path_player.sv
// Directed bench for rat_path_player: a coordinate model feeds a scoreboard queue that a
// negedge monitor drains on every output handshake. A STEP_W=2 twin checks saturation.
module tb_rat_path_player;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, mv_valid = 1'b0, mv_last = 1'b0, out_ready = 1'b0;
  logic [1:0] mv_dir = 2'b00;
  logic       mv_ready, out_valid, busy, done, err;
  logic [3:0] out_x, out_y;
  logic [7:0] step_cnt;
  logic       s_mv_ready, s_out_valid, s_busy, s_done, s_err;
  logic [3:0] s_out_x, s_out_y;
  logic [1:0] s_step;

  int         n_chk = 0, n_pass = 0, n_fail = 0, n_pops = 0;
  logic [7:0] exp_q[$];
  logic [3:0] ex_x = 4'd0, ex_y = 4'd0;
  int         w, pops0, idx;
  logic [1:0] bp_dirs [10] = '{2'b11, 2'b01, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00, 2'b01, 2'b11};

  always #5 clk = ~clk;

  rat_path_player #(.X_W(4), .Y_W(4), .FIFO_DEPTH(8), .STEP_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mv_valid(mv_valid), .mv_dir(mv_dir),
    .mv_last(mv_last), .mv_ready(mv_ready), .out_valid(out_valid), .out_x(out_x),
    .out_y(out_y), .out_ready(out_ready), .step_cnt(step_cnt), .busy(busy),
    .done(done), .err(err));

  rat_path_player #(.X_W(4), .Y_W(4), .FIFO_DEPTH(8), .STEP_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .mv_valid(mv_valid), .mv_dir(mv_dir),
    .mv_last(mv_last), .mv_ready(s_mv_ready), .out_valid(s_out_valid), .out_x(s_out_x),
    .out_y(s_out_y), .out_ready(out_ready), .step_cnt(s_step), .busy(s_busy),
    .done(s_done), .err(s_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_push(input logic [1:0] d);
    case (d)
      2'b00:   ex_x = ex_x - 4'd1;
      2'b11:   ex_x = ex_x + 4'd1;
      2'b01:   ex_y = ex_y + 4'd1;
      default: ex_y = ex_y - 4'd1;
    endcase
    exp_q.push_back({ex_x, ex_y});
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    ex_x = 4'd0;
    ex_y = 4'd0;
    exp_q.push_back(8'h00);
  endtask

  task automatic send(input logic [1:0] d, input logic last, output int waited);
    logic hs;
    hs = 1'b0;
    waited = 0;
    mv_valid = 1'b1;
    mv_dir = d;
    mv_last = last;
    for (int c = 0; c < 100 && !hs; c++) begin
      @(negedge clk);
      if (mv_ready) begin
        model_push(d);
        hs = 1'b1;
      end else begin
        waited++;
      end
      tick();
    end
    mv_valid = 1'b0;
    mv_last = 1'b0;
    chk("send_accept", {31'd0, hs}, 32'd1);
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else chk("busy_before_done", {31'd0, busy}, 32'd1);
      tick();
    end
    chk("done_reached", {31'd0, seen}, 32'd1);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  // Scoreboard: every output handshake must match the oldest expected coordinate.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      chk("sb_expected_present", {31'd0, (exp_q.size() != 0)}, 32'd1);
      if (exp_q.size() != 0) begin
        chk("sb_x", {28'd0, out_x}, {28'd0, exp_q[0][7:4]});
        chk("sb_y", {28'd0, out_y}, {28'd0, exp_q[0][3:0]});
        void'(exp_q.pop_front());
      end
      n_pops++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    tick();
    tick();
    @(negedge clk);
    chk("rst_mv_ready", {31'd0, mv_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_xy", {24'd0, out_x, out_y}, 32'd0);
    chk("rst_step", {24'd0, step_cnt}, 32'd0);
    chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Basic path with origin timing and full throughput.
    out_ready = 1'b1;
    do_start();
    @(negedge clk);
    chk("origin_not_yet", {31'd0, out_valid}, 32'd0);
    chk("origin_busy", {31'd0, busy}, 32'd1);
    tick();
    @(negedge clk);
    chk("origin_valid", {31'd0, out_valid}, 32'd1);
    tick();
    send(2'b11, 1'b0, w); chk("tput_wait", w, 32'd0);
    send(2'b11, 1'b0, w); chk("tput_wait", w, 32'd0);
    send(2'b01, 1'b0, w); chk("tput_wait", w, 32'd0);
    send(2'b01, 1'b1, w); chk("tput_wait", w, 32'd0);
    wait_done();
    chk("basic_step", {24'd0, step_cnt}, 32'd4);
    chk("basic_sat_step", {30'd0, s_step}, 32'd3);

    // Restart from DONE, with start ignored while running.
    do_start();
    @(negedge clk);
    chk("restart_done_clr", {31'd0, done}, 32'd0);
    chk("restart_step_clr", {24'd0, step_cnt}, 32'd0);
    tick();
    send(2'b01, 1'b0, w);
    start = 1'b1;
    send(2'b11, 1'b0, w);
    start = 1'b0;
    send(2'b01, 1'b1, w);
    wait_done();
    chk("restart_step", {24'd0, step_cnt}, 32'd3);

    // Backpressure: only the free FIFO slots after the origin accept moves.
    out_ready = 1'b0;
    pops0 = n_pops;
    do_start();
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      mv_valid = 1'b1;
      mv_dir = bp_dirs[idx];
      mv_last = (idx == 9);
      @(negedge clk);
      if (mv_ready) begin
        model_push(bp_dirs[idx]);
        idx++;
      end
      tick();
    end
    chk("bp_accepted", idx, 32'd7);
    chk("bp_ready_low", {31'd0, mv_ready}, 32'd0);
    chk("bp_step", {24'd0, step_cnt}, 32'd7);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_full", {31'd0, mv_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("bp_ready_rise", {31'd0, mv_ready}, 32'd1);
    model_push(bp_dirs[idx]);
    idx++;
    tick();
    mv_valid = 1'b0;
    send(bp_dirs[8], 1'b0, w);
    send(bp_dirs[9], 1'b1, w);
    wait_done();
    chk("bp_pop_count", n_pops - pops0, 32'd11);
    chk("bp_step_final", {24'd0, step_cnt}, 32'd10);
    chk("sat_step", {30'd0, s_step}, 32'd3);

    // First move leaves the maze at x = 0.
    do_start();
`ifdef RAT_PLAYER_BOUNDS_CHK_EN
    tick();
    mv_valid = 1'b1;
    mv_dir = 2'b00;
    @(negedge clk);
    chk("oob_ready_low", {31'd0, mv_ready}, 32'd0);
    tick();
    mv_valid = 1'b0;
    @(negedge clk);
    chk("oob_err", {31'd0, err}, 32'd1);
    chk("oob_flushed", {31'd0, out_valid}, 32'd0);
    chk("oob_step", {24'd0, step_cnt}, 32'd0);
    chk("oob_busy", {31'd0, busy}, 32'd0);
    tick();
`else
    send(2'b00, 1'b1, w);
    wait_done();
    chk("wrap_step", {24'd0, step_cnt}, 32'd1);
    chk("wrap_err", {31'd0, err}, 32'd0);
`endif

    // Reset mid-path discards everything, then a clean replay.
    out_ready = 1'b0;
    do_start();
    send(2'b11, 1'b0, w);
    send(2'b01, 1'b0, w);
    send(2'b11, 1'b0, w);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("mid_rst_mv_ready", {31'd0, mv_ready}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_xy", {24'd0, out_x, out_y}, 32'd0);
    chk("mid_rst_step", {24'd0, step_cnt}, 32'd0);
    chk("mid_rst_flags", {29'd0, busy, done, err}, 32'd0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    do_start();
    send(2'b01, 1'b0, w);
    send(2'b11, 1'b1, w);
    wait_done();
    chk("replay_step", {24'd0, step_cnt}, 32'd2);
    chk("replay_sat_step", {30'd0, s_step}, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
